// File: rtl/udl_cnt_defs.sv
// Shared definitions for the udl_cnt counter family.
//   UDL_WRAP / UDL_SAT : limit-handling mode constants for the SAT parameter
//   UDL_CH_SLICE(k, w) : part-select of channel k in a flat k*w bus
`ifndef UDL_CNT_DEFS_SV
`define UDL_CNT_DEFS_SV
`define UDL_CH_SLICE(k, w) [(k)*(w) +: (w)]
`endif

package udl_cnt_defs;

  localparam int unsigned UDL_WRAP = 0;
  localparam int unsigned UDL_SAT  = 1;

endpackage

// File: rtl/udl_cnt_ch.sv
// One channel of the up/down/load counter bank: step arithmetic, wrap or
// saturate at 0/MAXV, registered terminal-count pulse, optional TMR storage.
//   clk, rst_n   : clock, async active-low reset
//   ce, l, up    : count enable, synchronous load, direction (1 = up)
//   d            : load value (clamped to MAXV)
//   step         : count magnitude (clamped to MAXV)
//   q            : current count (voted when TMR=1)
//   tc           : terminal-count pulse, high while q shows a wrapped/saturated value
//   mismatch_c   : a TMR copy currently disagrees with the vote (0 when TMR=0)
module udl_cnt_ch
  import udl_cnt_defs::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAXV  = (2**WIDTH) - 1,
  parameter int unsigned SAT   = UDL_WRAP,
  parameter int unsigned TMR   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             l,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             mismatch_c
);

  // One extra bit so cnt+step and cnt+(MAXV+1) never overflow.
  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [W1-1:0] MAXV_X  = W1'(MAXV);
  localparam logic [W1-1:0] MODULUS = W1'(MAXV + 1);

  (* syn_keep = 1 *) logic [WIDTH-1:0] cnt_v;

  logic [WIDTH-1:0] nxt;
  logic             tc_nxt;
  logic [W1-1:0]    cnt_x;
  logic [W1-1:0]    d_x;
  logic [W1-1:0]    step_e;
  logic [W1-1:0]    sum;
  logic             tc_r;

  // Next-count and terminal-count decode, always from the voted value.
  always_comb begin
    nxt    = cnt_v;
    tc_nxt = 1'b0;
    cnt_x  = {1'b0, cnt_v};
    d_x    = {1'b0, d};
    step_e = ({1'b0, step} > MAXV_X) ? MAXV_X : {1'b0, step};
    sum    = cnt_x + step_e;
    if (l) begin
      nxt = (d_x > MAXV_X) ? WIDTH'(MAXV_X) : d;
    end else if (ce) begin
      if (up) begin
        if (sum > MAXV_X) begin
          tc_nxt = 1'b1;
          nxt    = (SAT == UDL_SAT) ? WIDTH'(MAXV_X) : WIDTH'(sum - MODULUS);
        end else begin
          nxt = WIDTH'(sum);
        end
      end else if (cnt_x >= step_e) begin
        nxt = WIDTH'(cnt_x - step_e);
      end else begin
        tc_nxt = 1'b1;
        nxt    = (SAT == UDL_SAT) ? '0 : WIDTH'(cnt_x + MODULUS - step_e);
      end
    end
  end

  // Terminal-count pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_r <= 1'b0;
    end else begin
      tc_r <= tc_nxt;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      (* syn_preserve = 1 *) logic [WIDTH-1:0] cnt0_r;
      (* syn_preserve = 1 *) logic [WIDTH-1:0] cnt1_r;
      (* syn_preserve = 1 *) logic [WIDTH-1:0] cnt2_r;

      // All copies written every cycle, so a single upset is scrubbed in one edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt0_r <= '0;
          cnt1_r <= '0;
          cnt2_r <= '0;
        end else begin
          cnt0_r <= nxt;
          cnt1_r <= nxt;
          cnt2_r <= nxt;
        end
      end

      udl_cnt_vote #(
        .WIDTH (WIDTH)
      ) u_vote (
        .a   (cnt0_r),
        .b   (cnt1_r),
        .c   (cnt2_r),
        .y_c (cnt_v)
      );

      assign mismatch_c = (|(cnt0_r ^ cnt_v)) | (|(cnt1_r ^ cnt_v)) | (|(cnt2_r ^ cnt_v));
    end else begin : g_single
      logic [WIDTH-1:0] cnt_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= nxt;
        end
      end

      assign cnt_v      = cnt_r;
      assign mismatch_c = 1'b0;
    end
  endgenerate

  assign q  = cnt_v;
  assign tc = tc_r;

endmodule

// File: rtl/udl_cnt_vote.sv
// Bitwise 2-of-3 majority voter used by the TMR counter registers.
//   a, b, c : the three register copies
//   y_c     : combinational voted value
module udl_cnt_vote #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y_c
);

  assign y_c = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/udl_cnt_nch.sv
// N-channel up/down/load counter bank with programmable step, wrap/saturate
// limit handling, terminal-count pulses, optional TMR and a sticky SEU flag.
//   CLK, RST_N : clock, async active-low reset
//   CE, L, UP  : per-channel enable, load, direction
//   D          : per-channel load values, channel k at [k*Width +: Width]
//   STEP       : shared step magnitude
//   CLR_ERR    : clears SEU_ERR (a simultaneous new mismatch wins)
//   Q          : per-channel counts, channel k at [k*Width +: Width]
//   TC         : per-channel terminal-count pulses
//   SEU_ERR    : sticky TMR disagreement flag (0 when TMR=0)
module udl_cnt_nch
  import udl_cnt_defs::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned NCH   = 1,
  parameter int unsigned MAXV  = (2**Width) - 1,
  parameter int unsigned SAT   = UDL_WRAP,
  parameter int unsigned TMR   = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NCH-1:0]       CE,
  input  logic [NCH-1:0]       L,
  input  logic [NCH-1:0]       UP,
  input  logic [NCH*Width-1:0] D,
  input  logic [Width-1:0]     STEP,
  input  logic                 CLR_ERR,
  output logic [NCH*Width-1:0] Q,
  output logic [NCH-1:0]       TC,
  output logic                 SEU_ERR
);

  logic [NCH-1:0] mism_c;

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      udl_cnt_ch #(
        .WIDTH (Width),
        .MAXV  (MAXV),
        .SAT   (SAT),
        .TMR   (TMR)
      ) u_ch (
        .clk        (CLK),
        .rst_n      (RST_N),
        .ce         (CE[k]),
        .l          (L[k]),
        .up         (UP[k]),
        .d          (D `UDL_CH_SLICE(k, Width)),
        .step       (STEP),
        .q          (Q `UDL_CH_SLICE(k, Width)),
        .tc         (TC[k]),
        .mismatch_c (mism_c[k])
      );
    end

    if (TMR != 0) begin : g_seu
      logic seu_err_r;

      // Sticky error flag; a new mismatch takes priority over the clear.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          seu_err_r <= 1'b0;
        end else if (|mism_c) begin
          seu_err_r <= 1'b1;
        end else if (CLR_ERR) begin
          seu_err_r <= 1'b0;
        end
      end

      assign SEU_ERR = seu_err_r;
    end else begin : g_no_seu
      logic unused_err;
      assign unused_err = CLR_ERR | (|mism_c);
      assign SEU_ERR    = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_udl_cnt_nch.sv
// Self-checking bench for udl_cnt_nch: three 2-channel, 4-bit instances
// (wrap MAXV=9, saturate MAXV=9, TMR wrap MAXV=15) driven with shared stimulus
// and checked against a scoreboard filled by a behavioural model.
module tb_udl_cnt_nch;

  typedef struct packed {
    logic [2:0][7:0] q;
    logic [2:0][1:0] tc;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic [1:0] CE;
  logic [1:0] L;
  logic [1:0] UP;
  logic [7:0] D;
  logic [3:0] STEP;
  logic       CLR_ERR;

  logic [7:0] q_w, q_s, q_t;
  logic [1:0] tc_w, tc_s, tc_t;
  logic       seu_w, seu_s, seu_t;

  logic [2:0][7:0] q_all;
  logic [2:0][1:0] tc_all;
  logic [2:0]      seu_all;

  assign q_all   = {q_t, q_s, q_w};
  assign tc_all  = {tc_t, tc_s, tc_w};
  assign seu_all = {seu_t, seu_s, seu_w};

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   m_cnt [3][2];
  int   m_maxv [3] = '{9, 9, 15};
  bit   m_sat  [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] flip;

  udl_cnt_nch #(.Width(4), .NCH(2), .MAXV(9), .SAT(0), .TMR(0)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .L(L), .UP(UP), .D(D), .STEP(STEP),
    .CLR_ERR(CLR_ERR), .Q(q_w), .TC(tc_w), .SEU_ERR(seu_w)
  );

  udl_cnt_nch #(.Width(4), .NCH(2), .MAXV(9), .SAT(1), .TMR(0)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .L(L), .UP(UP), .D(D), .STEP(STEP),
    .CLR_ERR(CLR_ERR), .Q(q_s), .TC(tc_s), .SEU_ERR(seu_s)
  );

  udl_cnt_nch #(.Width(4), .NCH(2), .MAXV(15), .SAT(0), .TMR(1)) dut_t (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .L(L), .UP(UP), .D(D), .STEP(STEP),
    .CLR_ERR(CLR_ERR), .Q(q_t), .TC(tc_t), .SEU_ERR(seu_t)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus, push the model's expectation, advance past the edge.
  task automatic apply(input logic [1:0] ce, input logic [1:0] l, input logic [1:0] up,
                       input logic [7:0] d, input logic [3:0] st);
    exp_t e;
    @(negedge CLK);
    CE = ce; L = l; UP = up; D = d; STEP = st;
    e = '0;
    for (int di = 0; di < 3; di++) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        int mx;
        int s;
        bit t;
        c  = m_cnt[di][k];
        mx = m_maxv[di];
        s  = (int'(st) > mx) ? mx : int'(st);
        t  = 1'b0;
        if (l[k]) begin
          c = int'(d[k*4 +: 4]);
          if (c > mx) c = mx;
        end else if (ce[k]) begin
          if (up[k]) begin
            c = c + s;
            if (c > mx) begin
              t = 1'b1;
              c = m_sat[di] ? mx : c - (mx + 1);
            end
          end else if (c >= s) begin
            c = c - s;
          end else begin
            t = 1'b1;
            c = m_sat[di] ? 0 : c + (mx + 1) - s;
          end
        end
        m_cnt[di][k]        = c;
        e.q[di][k*4 +: 4]   = 4'(c);
        e.tc[di][k]         = t;
      end
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int di = 0; di < 3; di++)
      for (int k = 0; k < 2; k++)
        m_cnt[di][k] = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t got;
    RST_N = 1'b0; CE = '0; L = '0; UP = '0; D = '0; STEP = '0; CLR_ERR = 1'b0;
    model_reset();
    #1;
    for (int di = 0; di < 3; di++) begin
      checks++;
      if (q_all[di] !== 8'h00 || tc_all[di] !== 2'b00 || seu_all[di] !== 1'b0) begin
        failures++;
        $display("FAIL reset_init dut%0d: q=%h tc=%b seu=%b want q=00 tc=00 seu=0",
                 di, q_all[di], tc_all[di], seu_all[di]);
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int n = 0; n < 6; n++) begin
      apply(2'b11, 2'b00, 2'b01, 8'h00, 4'd2);
      got = sb.pop_front();
      for (int di = 0; di < 3; di++) begin
        checks++;
        if (q_all[di] !== got.q[di] || tc_all[di] !== got.tc[di]) begin
          failures++;
          $display("FAIL reset_precount dut%0d: q=%h tc=%b want q=%h tc=%b",
                   di, q_all[di], tc_all[di], got.q[di], got.tc[di]);
        end
      end
    end
    // Assert reset between clock edges and check before the next rising edge.
    #2;
    RST_N = 1'b0;
    #1;
    for (int di = 0; di < 3; di++) begin
      checks++;
      if (q_all[di] !== 8'h00 || tc_all[di] !== 2'b00 || seu_all[di] !== 1'b0) begin
        failures++;
        $display("FAIL reset_async dut%0d: q=%h tc=%b seu=%b want q=00 tc=00 seu=0",
                 di, q_all[di], tc_all[di], seu_all[di]);
      end
    end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t got;
    apply(2'b00, 2'b11, 2'b00, 8'h88, 4'd0);
    got = sb.pop_front();
    for (int n = 0; n < 3; n++) begin
      if (n > 0) begin
        apply(2'b01, 2'b00, 2'b01, 8'h00, 4'd3);
        got = sb.pop_front();
      end
      for (int di = 0; di < 3; di++) begin
        checks++;
        if (q_all[di] !== got.q[di] || tc_all[di] !== got.tc[di]) begin
          failures++;
          $display("FAIL wrap_up step%0d dut%0d: q=%h tc=%b want q=%h tc=%b",
                   n, di, q_all[di], tc_all[di], got.q[di], got.tc[di]);
        end
      end
    end
    // Explicit anchor: wrap instance ch0 went 8 -> 1 -> 4.
    checks++;
    if (q_w[3:0] !== 4'd4 || tc_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_up_final: q=%0d tc=%b want q=4 tc=0", q_w[3:0], tc_w[0]);
    end
  endtask

  task automatic test_sat_down();
    exp_t got;
    apply(2'b00, 2'b11, 2'b00, 8'h22, 4'd0);
    got = sb.pop_front();
    for (int n = 0; n < 4; n++) begin
      apply(2'b11, 2'b00, 2'b00, 8'h00, 4'd3);
      got = sb.pop_front();
      for (int di = 0; di < 3; di++) begin
        checks++;
        if (q_all[di] !== got.q[di] || tc_all[di] !== got.tc[di]) begin
          failures++;
          $display("FAIL sat_down step%0d dut%0d: q=%h tc=%b want q=%h tc=%b",
                   n, di, q_all[di], tc_all[di], got.q[di], got.tc[di]);
        end
      end
      checks++;
      if (q_s !== 8'h00 || tc_s !== 2'b11) begin
        failures++;
        $display("FAIL sat_down_anchor step%0d: q=%h tc=%b want q=00 tc=11", n, q_s, tc_s);
      end
    end
  endtask

  task automatic test_priority();
    exp_t got;
    apply(2'b00, 2'b11, 2'b00, 8'h70, 4'd0);
    got = sb.pop_front();
    apply(2'b11, 2'b01, 2'b10, 8'h05, 4'd1);
    got = sb.pop_front();
    for (int di = 0; di < 3; di++) begin
      checks++;
      if (q_all[di] !== got.q[di] || tc_all[di] !== got.tc[di]) begin
        failures++;
        $display("FAIL priority dut%0d: q=%h tc=%b want q=%h tc=%b",
                 di, q_all[di], tc_all[di], got.q[di], got.tc[di]);
      end
    end
    checks++;
    if (q_w !== 8'h85) begin
      failures++;
      $display("FAIL priority_anchor: q=%h want 85", q_w);
    end
    apply(2'b00, 2'b11, 2'b00, 8'hFF, 4'd0);
    got = sb.pop_front();
    for (int di = 0; di < 3; di++) begin
      checks++;
      if (q_all[di] !== got.q[di] || tc_all[di] !== got.tc[di]) begin
        failures++;
        $display("FAIL load_clamp dut%0d: q=%h tc=%b want q=%h tc=%b",
                 di, q_all[di], tc_all[di], got.q[di], got.tc[di]);
      end
    end
    checks++;
    if (q_w !== 8'h99) begin
      failures++;
      $display("FAIL load_clamp_anchor: q=%h want 99", q_w);
    end
  endtask

  task automatic test_step_zero();
    exp_t got;
    apply(2'b00, 2'b11, 2'b00, 8'h93, 4'd0);
    got = sb.pop_front();
    for (int n = 0; n < 4; n++) begin
      apply(2'b11, 2'b00, 2'(n), 8'h00, 4'd0);
      got = sb.pop_front();
      for (int di = 0; di < 3; di++) begin
        checks++;
        if (q_all[di] !== got.q[di] || tc_all[di] !== 2'b00) begin
          failures++;
          $display("FAIL step_zero dut%0d: q=%h tc=%b want q=%h tc=00",
                   di, q_all[di], tc_all[di], got.q[di]);
        end
      end
    end
    for (int n = 0; n < 100; n++) begin
      apply(2'b00, 2'b00, 2'($urandom_range(3)), 8'($urandom), 4'($urandom));
      got = sb.pop_front();
      checks++;
      if (q_all !== got.q || tc_all !== 6'b0) begin
        failures++;
        $display("FAIL hold cycle%0d: q=%h tc=%h want q=%h tc=0", n, q_all, tc_all, got.q);
      end
    end
  endtask

  task automatic test_tmr_scrub();
    exp_t got;
    apply(2'b00, 2'b11, 2'b00, 8'h6A, 4'd0);
    got = sb.pop_front();
    flip = 4'(m_cnt[2][0]) ^ 4'b0100;
    force dut_t.g_ch[0].u_ch.g_tmr.cnt2_r = flip;
    #1;
    checks++;
    if (q_t[3:0] !== 4'(m_cnt[2][0]) || seu_t !== 1'b0) begin
      failures++;
      $display("FAIL tmr_vote: q=%h seu=%b want q=%h seu=0", q_t[3:0], seu_t, 4'(m_cnt[2][0]));
    end
    apply(2'b00, 2'b00, 2'b00, 8'h00, 4'd0);
    release dut_t.g_ch[0].u_ch.g_tmr.cnt2_r;
    got = sb.pop_front();
    checks++;
    if (q_all !== got.q || seu_t !== 1'b1) begin
      failures++;
      $display("FAIL tmr_seu_set: q=%h seu=%b want q=%h seu=1", q_all, seu_t, got.q);
    end
    apply(2'b00, 2'b00, 2'b00, 8'h00, 4'd0);
    got = sb.pop_front();
    checks++;
    if (dut_t.g_ch[0].u_ch.g_tmr.cnt2_r !== 4'(m_cnt[2][0])) begin
      failures++;
      $display("FAIL tmr_scrub: copy2=%h want %h", dut_t.g_ch[0].u_ch.g_tmr.cnt2_r, 4'(m_cnt[2][0]));
    end
    apply(2'b00, 2'b00, 2'b00, 8'h00, 4'd0);
    got = sb.pop_front();
    checks++;
    if (seu_t !== 1'b1 || q_t !== got.q[2]) begin
      failures++;
      $display("FAIL tmr_sticky: seu=%b q=%h want seu=1 q=%h", seu_t, q_t, got.q[2]);
    end
    CLR_ERR = 1'b1;
    apply(2'b00, 2'b00, 2'b00, 8'h00, 4'd0);
    CLR_ERR = 1'b0;
    got = sb.pop_front();
    checks++;
    if (seu_all !== 3'b000) begin
      failures++;
      $display("FAIL tmr_clear: seu=%b want 000", seu_all);
    end
  endtask

  task automatic test_random();
    exp_t got;
    for (int n = 0; n < 300; n++) begin
      apply(2'($urandom), ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00,
            2'($urandom), 8'($urandom), 4'($urandom));
      got = sb.pop_front();
      checks++;
      if (q_all !== got.q || tc_all !== got.tc || seu_all !== 3'b000) begin
        failures++;
        $display("FAIL random cycle%0d: q=%h tc=%h seu=%b want q=%h tc=%h seu=000",
                 n, q_all, tc_all, seu_all, got.q, got.tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority();
    test_step_zero();
    test_tmr_scrub();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
